// File: rtl/mul_popcnt_core.sv
// Shift-add 24x24 multiplier followed by a population count of the 48-bit product.
// Define MULPOP_FAST_COUNT_EN to count 4 product bits per cycle instead of 1.
module mul_popcnt_core #(
  parameter int OP_W  = 24,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             clear,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  a2,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] w,
  output logic [OP_W-1:0]  l,
  output logic [1:0]       status
);
  localparam int PW = 2 * OP_W;
`ifdef MULPOP_FAST_COUNT_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif
  localparam int CITER = PW / STEP;
  localparam int IW    = $clog2(PW);
  localparam int CW    = $clog2(PW + 1);

  typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   mcand, acc, sh;
  logic [OP_W-1:0] mplier;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   ones;
  logic [PW-1:0]   acc_nxt;
  logic [CW-1:0]   ones_nxt;

  always_comb begin
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
    ones_nxt = ones;
    for (int i = 0; i < STEP; i++) ones_nxt = ones_nxt + CW'(sh[i]);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sh     <= '0;
      idx    <= '0;
      ones   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      w      <= '0;
      l      <= '0;
      status <= 2'b11;
    end else if (clear) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      w      <= '0;
      l      <= '0;
      status <= 2'b11;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= {{OP_W{1'b0}}, a1};
          mplier <= a2;
          acc    <= '0;
          ones   <= '0;
          idx    <= '0;
          w      <= '0;
          l      <= '0;
          busy   <= 1'b1;
          status <= 2'b00;
          state  <= MULT;
        end
        MULT: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          idx    <= idx + IW'(1);
          if (idx == IW'(OP_W - 1)) begin
            // final partial product lands this edge, so seed the counter from acc_nxt
            sh    <= acc_nxt;
            idx   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          ones <= ones_nxt;
          sh   <= sh >> STEP;
          idx  <= idx + IW'(1);
          if (idx == IW'(CITER - 1)) begin
            w      <= acc[RES_W-1:0];
            l      <= {{(OP_W - CW){1'b0}}, ones_nxt};
            status <= (|acc[PW-1:RES_W]) ? 2'b10 : 2'b01;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
